// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encoding,
// default operand width and a counter-width helper.
package arith_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-and-add partial-product step on the {acc, q} register.
// Purely combinational.
module mult_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_n,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] acc_t;

  always_comb begin
    sum   = {1'b0, acc[WIDTH-1:0]} + {1'b0, m};
    acc_t = q[0] ? sum : acc;
  end

  assign {acc_n, q_n} = {1'b0, acc_t, q[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier, one
// partial-product step per clock, WIDTH steps per product.
module seq_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [WIDTH:0] acc_n;
  logic [WIDTH-1:0] q_n;

  mult_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc  (acc_q),
    .q    (q_q),
    .m    (m_q),
    .acc_n(acc_n),
    .q_n  (q_n)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          m_d     = multiplicand;
          acc_d   = '0;
          q_d     = multiplier;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_n;
        q_d   = q_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          prod_d  = {acc_n[WIDTH-1:0], q_n};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags trail the state by one edge so that the busy
  // window and the done pulse line up with the fixed latency.
  always_comb begin
    busy_d = (state_q == RUN);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus queues expected
// products and done cycles, a negedge monitor checks them.
module tb_seq_multiplier;

  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] p;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int             cyc;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  exp_t sb[$];
  int   tests;
  int   fails;
  int   cyc;

  seq_multiplier #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .multiplicand(a_in),
    .multiplier  (b_in),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act,
                       input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) begin
        tests++;
        fails++;
        $display("FAIL busy_done_overlap: got 1, expected 0");
      end
      if (done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got product %0d, expected no done",
                   product);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", product, e.p);
          check("done_cycle", cyc, e.cyc);
          if (e.b != 0) begin
            check("div_quot", product / e.b, e.a);
            check("div_rem", product % e.b, 0);
          end
        end
      end
    end
  end

  // Accept happens on the first edge after the drive; done is due
  // nine edges later.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] p, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.p = p;
      e.a = a;
      e.b = b;
      e.cyc = cyc + 9;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    exp_t e;
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);

    // Basic product with busy window.
    issue(8'd13, 8'd11, 16'd143, 1);
    @(negedge clk);
    check("busy_after_k", busy, 0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("busy_window", busy, 1);
    end
    @(negedge clk);
    check("busy_at_done", busy, 0);
    drain();
    check("product_held", product, 143);

    issue(8'd255, 8'd255, 16'hFE01, 1);
    drain();
    issue(8'd0, 8'd200, 16'd0, 1);
    drain();

    // A start during RUN must not disturb the operation.
    issue(8'd7, 8'd9, 16'd63, 1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    a_in  = 8'd3;
    b_in  = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    check("ignored_start", product, 63);

    // Back-to-back with start held through the DONE cycle.
    @(posedge clk);
    #1;
    start = 1'b1;
    a_in  = 8'd12;
    b_in  = 8'd12;
    @(posedge clk);
    #1;
    e.p = 16'd144;
    e.a = 8'd12;
    e.b = 8'd12;
    e.cyc = cyc + 9;
    sb.push_back(e);
    a_in = 8'd100;
    b_in = 8'd2;
    repeat (9) @(posedge clk);
    #1;
    e.p = 16'd200;
    e.a = 8'd100;
    e.b = 8'd2;
    e.cyc = cyc + 9;
    sb.push_back(e);
    start = 1'b0;
    drain();

    // Reset during RUN aborts without a done.
    issue(8'd50, 8'd50, 16'd2500, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_product_later", product, 0);
    issue(8'd5, 8'd6, 16'd30, 1);
    drain();

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      issue(ra, rb, 16'(ra) * 16'(rb), 1);
      for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
